// File: rtl/commit_trace_checker.sv
// commit_trace_checker: compares each retired instruction against a FIFO of expected commit records.
// Raises sticky mismatch/underrun flags and reports pass once the HALT commit has been checked.
module commit_trace_checker #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_en,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        hlt,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [1:0]  exp_kind,
  input  logic [15:0] exp_pc,
  input  logic [3:0]  exp_reg,
  input  logic [15:0] exp_value,
  input  logic [15:0] exp_addr,
  output logic [15:0] inst_count,
  output logic        mismatch,
  output logic        underrun,
  output logic [15:0] err_inum,
  output logic        done,
  output logic        pass
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] KREG = 2'd0, KSTORE = 2'd1, KHALT = 2'd2, KNOP = 2'd3;
  typedef enum logic {RUN, DONE} state_t;
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] value;
    logic [15:0] addr;
  } rec_t;
  state_t state, nextState;
  rec_t fifo [FIFO_DEPTH];
  rec_t head;
  logic [AW:0] wrPtr, rdPtr;
  logic full, empty, run, push, pop, underrunNow, mismatchNow, firstErr, dataOk;
  logic [1:0] kind;
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_comb begin
    run = state == RUN;
    empty = wrPtr == rdPtr;
    full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    exp_ready = rst_n && run && !full;
    push = exp_valid && exp_ready;
    pop = run && commit_en && !empty;
    head = fifo[rdPtr[AW-1:0]];
    kind = reg_write ? KREG : hlt ? KHALT : mem_write ? KSTORE : KNOP;
    dataOk = kind == KREG ? (write_reg == head.rg && write_data == head.value) :
             kind == KSTORE ? (mem_addr == head.addr && mem_data == head.value) : 1'b1;
    mismatchNow = pop && !(head.kind == kind && head.pc == pc && dataOk);
    underrunNow = run && commit_en && empty;
    firstErr = (mismatchNow || underrunNow) && !mismatch && !underrun;
    nextState = (pop && kind == KHALT) ? DONE : state;
    done = state == DONE;
    pass = done && !mismatch && !underrun;
  end
  always_ff @(posedge clk)
    if (push) fifo[wrPtr[AW-1:0]] <= {exp_kind, exp_pc, exp_reg, exp_value, exp_addr};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      wrPtr <= '0;
      rdPtr <= '0;
      inst_count <= '0;
      mismatch <= 1'b0;
      underrun <= 1'b0;
      err_inum <= '0;
    end else begin
      state <= nextState;
      if (push) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop) rdPtr <= rdPtr + (AW+1)'(1);
      if (run && commit_en) inst_count <= inst_count + 16'd1;
      if (mismatchNow) mismatch <= 1'b1;
      if (underrunNow) underrun <= 1'b1;
      if (firstErr) err_inum <= inst_count;
    end
endmodule

// File: tb/tb_commit_trace_checker.sv
// tb_commit_trace_checker: directed vector table, an asynchronous-reset sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_commit_trace_checker;
  localparam int D = 4;
  logic clk = 0, rst_n = 0;
  logic commit_en = 0, reg_write = 0, mem_write = 0, hlt = 0, exp_valid = 0;
  logic [15:0] pc = 0, write_data = 0, mem_addr = 0, mem_data = 0;
  logic [15:0] exp_pc = 0, exp_value = 0, exp_addr = 0;
  logic [3:0] write_reg = 0, exp_reg = 0;
  logic [1:0] exp_kind = 0;
  logic exp_ready, mismatch, underrun, done, pass;
  logic [15:0] inst_count, err_inum;
  int checks = 0, fails = 0;

  typedef struct {
    int rst, ev, ek, epc, erg, eval, eadr;
    int ce, cpc, rw, wr, wd, mw, ma, md, h;
    int cnt, err, mm, ur, dn, ps, rdy;
  } vec_t;
  typedef struct {
    logic [1:0] k;
    logic [15:0] pc;
    logic [3:0] rg;
    logic [15:0] v, a;
  } rec_t;

  rec_t mq[$];
  logic [15:0] mCnt, mErr;
  logic mMm, mUr, mDone;

  always #5 clk = ~clk;

  commit_trace_checker #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .commit_en(commit_en), .pc(pc),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
    .exp_pc(exp_pc), .exp_reg(exp_reg), .exp_value(exp_value), .exp_addr(exp_addr),
    .inst_count(inst_count), .mismatch(mismatch), .underrun(underrun),
    .err_inum(err_inum), .done(done), .pass(pass)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    commit_en = 0; reg_write = 0; mem_write = 0; hlt = 0; exp_valid = 0;
    pc = 0; write_reg = 0; write_data = 0; mem_addr = 0; mem_data = 0;
    exp_kind = 0; exp_pc = 0; exp_reg = 0; exp_value = 0; exp_addr = 0;
  endtask

  task automatic doReset();
    rst_n = 0;
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    mq.delete();
    mCnt = 0; mErr = 0; mMm = 0; mUr = 0; mDone = 0;
  endtask

  task automatic drive(vec_t v);
    exp_valid = v.ev[0]; exp_kind = v.ek[1:0]; exp_pc = v.epc[15:0];
    exp_reg = v.erg[3:0]; exp_value = v.eval[15:0]; exp_addr = v.eadr[15:0];
    commit_en = v.ce[0]; pc = v.cpc[15:0]; reg_write = v.rw[0]; write_reg = v.wr[3:0];
    write_data = v.wd[15:0]; mem_write = v.mw[0]; mem_addr = v.ma[15:0];
    mem_data = v.md[15:0]; hlt = v.h[0];
  endtask

  // Reference: classify the commit, pop the oldest expected record, compare the fields
  // that matter for that kind, then append any record accepted on the same edge.
  task automatic modelStep();
    rec_t r;
    logic [1:0] k;
    logic bad, rdy, halt;
    rdy = !mDone && mq.size() < D;
    halt = 0;
    if (!mDone && commit_en) begin
      k = reg_write ? 2'd0 : hlt ? 2'd2 : mem_write ? 2'd1 : 2'd3;
      if (mq.size() == 0) begin
        if (!mMm && !mUr) mErr = mCnt;
        mUr = 1;
      end else begin
        r = mq.pop_front();
        bad = r.k != k || r.pc != pc ||
              (k == 2'd0 && (r.rg != write_reg || r.v != write_data)) ||
              (k == 2'd1 && (r.a != mem_addr || r.v != mem_data));
        if (bad) begin
          if (!mMm && !mUr) mErr = mCnt;
          mMm = 1;
        end
        halt = k == 2'd2;
      end
      mCnt = mCnt + 16'd1;
    end
    if (exp_valid && rdy) mq.push_back('{exp_kind, exp_pc, exp_reg, exp_value, exp_addr});
    if (halt) mDone = 1;
  endtask

  task automatic cmpModel();
    logic rdy;
    rdy = !mDone && mq.size() < D;
    chk("rnd inst_count", inst_count, mCnt);
    chk("rnd err_inum", err_inum, mErr);
    chk("rnd mismatch", {15'd0, mismatch}, {15'd0, mMm});
    chk("rnd underrun", {15'd0, underrun}, {15'd0, mUr});
    chk("rnd done", {15'd0, done}, {15'd0, mDone});
    chk("rnd pass", {15'd0, pass}, {15'd0, mDone && !mMm && !mUr});
    chk("rnd exp_ready", {15'd0, exp_ready}, {15'd0, rdy});
  endtask

  task automatic rndPhase(int n);
    rec_t r;
    int kk;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0 || (mDone && $urandom_range(0, 7) == 0)) doReset();
      exp_valid = $urandom_range(0, 2) != 0;
      kk = $urandom_range(0, 2);
      exp_kind = ($urandom_range(0, 19) == 0) ? 2'd2 : (kk == 2 ? 2'd3 : 2'(kk));
      exp_pc = 16'($urandom_range(0, 7));
      exp_reg = 4'($urandom);
      exp_value = 16'($urandom);
      exp_addr = 16'($urandom);
      commit_en = $urandom_range(0, 1);
      pc = 16'($urandom_range(0, 7));
      reg_write = $urandom_range(0, 3) == 0;
      hlt = $urandom_range(0, 15) == 0;
      mem_write = $urandom_range(0, 3) == 0;
      write_reg = 4'($urandom); write_data = 16'($urandom);
      mem_addr = 16'($urandom); mem_data = 16'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
        r = mq[0];
        pc = r.pc;
        reg_write = r.k == 2'd0;
        hlt = r.k == 2'd2 || (r.k == 2'd0 && $urandom_range(0, 1) == 1);
        mem_write = r.k == 2'd1 || ((r.k == 2'd0 || r.k == 2'd2) && $urandom_range(0, 1) == 1);
        if (r.k == 2'd0) begin write_reg = r.rg; write_data = r.v; end
        if (r.k == 2'd1) begin mem_addr = r.a; mem_data = r.v; end
        if ($urandom_range(0, 9) == 0) pc[$urandom_range(0, 15)] ^= 1'b1;
      end
      @(posedge clk);
      modelStep();
      #1;
      cmpModel();
    end
  endtask

  vec_t tab[19];

  initial begin
    tab = '{
      '{1,1,0,'h0,3,'h5,0,      0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,1},
      '{0,1,2,'h2,0,0,0,        1,'h0,1,3,'h5,0,0,0,0,       1,0,0,0,0,0,1},
      '{0,0,0,0,0,0,0,          1,'h2,0,0,0,0,0,0,1,         2,0,0,0,1,1,0},
      '{0,1,0,0,0,0,0,          1,'h4,0,0,0,0,0,0,1,         2,0,0,0,1,1,0},
      '{1,1,1,'h4,0,'hBEEF,'h10, 0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,1},
      '{0,0,0,0,0,0,0,          1,'h4,0,0,0,1,'h10,'hBEEE,0, 1,0,1,0,0,0,1},
      '{1,0,0,0,0,0,0,          1,'h0,0,0,0,0,0,0,0,         1,0,0,1,0,0,1},
      '{0,1,3,'h10,0,0,0,       1,'h0,0,0,0,0,0,0,0,         2,0,0,1,0,0,1},
      '{0,0,0,0,0,0,0,          1,'h10,0,0,0,0,0,0,0,        3,0,0,1,0,0,1},
      '{1,1,2,'h8,0,0,0,        0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,1},
      '{0,0,0,0,0,0,0,          1,'h8,1,1,0,0,0,0,1,         1,0,1,0,0,0,1},
      '{1,1,3,'h0,0,0,0,        0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,1},
      '{0,1,3,'h1,0,0,0,        0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,1},
      '{0,1,3,'h2,0,0,0,        0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,1},
      '{0,1,3,'h3,0,0,0,        0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,0},
      '{0,1,3,'h4,0,0,0,        1,'h0,0,0,0,0,0,0,0,         1,0,0,0,0,0,1},
      '{0,1,3,'h4,0,0,0,        0,0,0,0,0,0,0,0,0,           1,0,0,0,0,0,0},
      '{0,0,0,0,0,0,0,          1,'h1,0,0,0,0,0,0,0,         2,0,0,0,0,0,1},
      '{0,0,0,0,0,0,0,          1,'h7,0,0,0,0,0,0,0,         3,2,1,0,0,0,1}
    };
    doReset();
    #1;
    chk("reset inst_count", inst_count, 16'd0);
    chk("reset exp_ready", {15'd0, exp_ready}, 16'd1);
    chk("reset done", {15'd0, done}, 16'd0);
    for (int i = 0; i < 19; i++) begin
      if (tab[i].rst != 0) doReset();
      else @(negedge clk);
      drive(tab[i]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d inst_count", i), inst_count, tab[i].cnt[15:0]);
      chk($sformatf("vec%0d err_inum", i), err_inum, tab[i].err[15:0]);
      chk($sformatf("vec%0d mismatch", i), {15'd0, mismatch}, tab[i].mm[15:0]);
      chk($sformatf("vec%0d underrun", i), {15'd0, underrun}, tab[i].ur[15:0]);
      chk($sformatf("vec%0d done", i), {15'd0, done}, tab[i].dn[15:0]);
      chk($sformatf("vec%0d pass", i), {15'd0, pass}, tab[i].ps[15:0]);
      chk($sformatf("vec%0d exp_ready", i), {15'd0, exp_ready}, tab[i].rdy[15:0]);
    end
    // Asynchronous reset with three records buffered and mismatch already set.
    doReset();
    for (int i = 0; i < 4; i++) begin
      exp_valid = 1; exp_kind = 2'd3; exp_pc = 16'(i);
      @(posedge clk);
      @(negedge clk);
    end
    exp_valid = 0;
    commit_en = 1; reg_write = 1; pc = 16'd0;
    @(posedge clk);
    @(negedge clk);
    clearInputs();
    chk("async pre mismatch", {15'd0, mismatch}, 16'd1);
    chk("async pre inst_count", inst_count, 16'd1);
    #2 rst_n = 0;
    #1;
    chk("async inst_count", inst_count, 16'd0);
    chk("async mismatch", {15'd0, mismatch}, 16'd0);
    chk("async underrun", {15'd0, underrun}, 16'd0);
    chk("async err_inum", err_inum, 16'd0);
    chk("async done", {15'd0, done}, 16'd0);
    chk("async pass", {15'd0, pass}, 16'd0);
    chk("async exp_ready", {15'd0, exp_ready}, 16'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("release exp_ready", {15'd0, exp_ready}, 16'd1);
    commit_en = 1;
    @(posedge clk);
    #1;
    chk("post-reset underrun", {15'd0, underrun}, 16'd1);
    chk("post-reset mismatch", {15'd0, mismatch}, 16'd0);
    chk("post-reset inst_count", inst_count, 16'd1);
    @(negedge clk);
    clearInputs();
    doReset();
    rndPhase(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
